// File: rtl/pc_update_unit.sv
// Program-counter register stage with EPC and exception vector sequencer.
// PC is written from the PC source mux under unconditional or branch-
// conditional control; an exception saves PC-4 into EPC, fetches the
// handler byte from the vector table (bytes 253..255) and loads it into PC.
module pc_update_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_op,
    input  logic        alu_zero,
    input  logic        alu_gt,
    input  logic        exc_req,
    input  logic [1:0]  exc_code,
    input  logic [31:0] exc_vec_data,
    output logic [31:0] pc_out,
    output logic [31:0] epc_out,
    output logic        exc_busy,
    output logic        exc_mem_read,
    output logic [31:0] exc_vec_addr
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_VEC_REQ  = 2'd1,
        ST_VEC_WAIT = 2'd2,
        ST_VEC_LOAD = 2'd3
    } state_t;

    // Last wait-counter value before the vector byte is valid.
    localparam logic [2:0] WAIT_LAST = 3'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  code_q, code_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        rd_q, rd_d;
    logic [31:0] addr_q, addr_d;
    logic        take_s;
    logic        unused_vec_hi_s;

    // Branch condition evaluation from the ALU flags.
    function automatic logic branch_cond(input logic [1:0] op,
                                         input logic zero,
                                         input logic gt);
        logic c;
        case (op)
            2'b00:   c = zero;
            2'b01:   c = !zero;
            2'b10:   c = zero | !gt;
            2'b11:   c = gt;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    // Only the low byte of the vector word is a handler address.
    assign unused_vec_hi_s = ^exc_vec_data[31:8];

    // PC write enable: unconditional, or conditional with branch taken.
    always_comb begin
        take_s = pc_write | (pc_write_cond & branch_cond(branch_op, alu_zero, alu_gt));
    end

    // Next-state logic for the sequencer, PC, EPC, latched code and counter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_req) begin
                    // Exception wins over any PC write in the same cycle.
                    epc_d   = pc_q - 32'd4;
                    code_d  = (exc_code == 2'b11) ? 2'b00 : exc_code;
                    state_d = ST_VEC_REQ;
                end else if (take_s) begin
                    pc_d = pc_next;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_VEC_REQ: begin
                cnt_d   = 3'd0;
                state_d = ST_VEC_WAIT;
            end
            ST_VEC_WAIT: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_VEC_LOAD;
                end else begin
                    state_d = ST_VEC_WAIT;
                end
            end
            ST_VEC_LOAD: begin
                pc_d    = {24'h00_0000, exc_vec_data[7:0]};
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore output decodes, computed from the next state so they register in step with it.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        rd_d   = (state_d == ST_VEC_REQ) || (state_d == ST_VEC_WAIT);
        if (busy_d) begin
            addr_d = 32'd253 + {30'd0, code_d};
        end else begin
            addr_d = 32'd0;
        end
    end

    // State and output registers; reset aborts any sequence in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            epc_q   <= 32'd0;
            code_q  <= 2'd0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
        end
    end

    assign pc_out       = pc_q;
    assign epc_out      = epc_q;
    assign exc_busy     = busy_q;
    assign exc_mem_read = rd_q;
    assign exc_vec_addr = addr_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit: directed branch table, exception
// sequences, mid-sequence reset, and randomized traffic against a
// cycle-countdown reference model.
module tb_pc_update_unit;

    localparam int ML = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  branch_op;
    logic        alu_zero;
    logic        alu_gt;
    logic        exc_req;
    logic [1:0]  exc_code;
    logic [31:0] exc_vec_data;
    logic [31:0] pc_out;
    logic [31:0] epc_out;
    logic        exc_busy;
    logic        exc_mem_read;
    logic [31:0] exc_vec_addr;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: remaining cycles of an exception (0 = idle).
    logic [31:0] m_pc, m_epc, m_vec;
    int          m_rem;

    pc_update_unit #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(ML)) dut (
        .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .branch_op(branch_op),
        .alu_zero(alu_zero), .alu_gt(alu_gt), .exc_req(exc_req),
        .exc_code(exc_code), .exc_vec_data(exc_vec_data), .pc_out(pc_out),
        .epc_out(epc_out), .exc_busy(exc_busy), .exc_mem_read(exc_mem_read),
        .exc_vec_addr(exc_vec_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        wc;
        logic [1:0]  op;
        logic        z;
        logic        gt;
        logic [31:0] nxt;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic taken(input logic [1:0] op, input logic z, input logic gt);
        if (op == 2'b00) return z;
        if (op == 2'b01) return !z;
        if (op == 2'b10) return z || !gt;
        return gt;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_vec = 32'h0; m_rem = 0;
    endtask

    // Model update applied at each rising edge using the inputs currently driven.
    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else if (m_rem == 0) begin
            if (exc_req) begin
                m_epc = m_pc - 32'd4;
                m_vec = 32'd253 + ((exc_code == 2'b11) ? 32'd0 : 32'(exc_code));
                m_rem = ML + 2;
            end else if (pc_write || (pc_write_cond && taken(branch_op, alu_zero, alu_gt))) begin
                m_pc = pc_next;
            end
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) m_pc = exc_vec_data & 32'h0000_00FF;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},   pc_out,  m_pc);
        chk({tag, ".epc"},  epc_out, m_epc);
        chk({tag, ".busy"}, {31'd0, exc_busy}, (m_rem != 0) ? 32'd1 : 32'd0);
        chk({tag, ".rd"},   {31'd0, exc_mem_read}, (m_rem > 1) ? 32'd1 : 32'd0);
        chk({tag, ".addr"}, exc_vec_addr, (m_rem != 0) ? m_vec : 32'd0);
    endtask

    // One clock: edge, model update, then sample at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pc_write = 1'b0; pc_write_cond = 1'b0; branch_op = 2'b00;
        alu_zero = 1'b0; alu_gt = 1'b0; exc_req = 1'b0; exc_code = 2'b00;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h40, 32'h10};
        tbl[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h40, 32'h40};
        tbl[2]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'h50, 32'h50};
        tbl[3]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'h60, 32'h50};
        tbl[4]  = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h24, 32'h24};
        tbl[5]  = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h80, 32'h80};
        tbl[6]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b1, 32'h90, 32'h80};
        tbl[7]  = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 32'h94, 32'h94};
        tbl[8]  = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'h98, 32'h94};
        tbl[9]  = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 32'h9C, 32'h9C};
        tbl[10] = '{1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 32'hA0, 32'h9C};
        tbl[11] = '{1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h24, 32'h24};

        // Reset held low while a write is requested.
        idle_inputs();
        exc_vec_data = 32'h0;
        reset = 1'b0; pc_write = 1'b1; pc_next = 32'h10;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst.pc", pc_out, 32'h0);
        chk("rst.epc", epc_out, 32'h0);
        chk("rst.busy", {31'd0, exc_busy}, 32'd0);
        chk("rst.rd", {31'd0, exc_mem_read}, 32'd0);
        chk("rst.addr", exc_vec_addr, 32'h0);
        reset = 1'b1;
        step();
        chk("rel.pc", pc_out, 32'h10);
        check_model("rel");

        // Directed branch/write table.
        for (int i = 0; i < 12; i++) begin
            pc_write = tbl[i].wr; pc_write_cond = tbl[i].wc; branch_op = tbl[i].op;
            alu_zero = tbl[i].z; alu_gt = tbl[i].gt; pc_next = tbl[i].nxt;
            step();
            chk($sformatf("tbl%0d.pc", i), pc_out, tbl[i].exp_pc);
        end

        // Exception at PC=0x24, code 01, with a competing pc_write.
        idle_inputs();
        exc_req = 1'b1; exc_code = 2'b01; pc_write = 1'b1; pc_next = 32'h1234;
        exc_vec_data = 32'h1234_56A8;
        step();
        chk("exc1.epc", epc_out, 32'h20);
        chk("exc1.pc_hold", pc_out, 32'h24);
        chk("exc1.addr", exc_vec_addr, 32'd254);
        chk("exc1.rd", {31'd0, exc_mem_read}, 32'd1);
        exc_req = 1'b0;
        step();
        chk("exc1.wait_rd", {31'd0, exc_mem_read}, 32'd1);
        step();
        chk("exc1.load_busy", {31'd0, exc_busy}, 32'd1);
        chk("exc1.load_rd", {31'd0, exc_mem_read}, 32'd0);
        chk("exc1.load_pc", pc_out, 32'h24);
        step();
        chk("exc1.pc", pc_out, 32'hA8);
        chk("exc1.busy", {31'd0, exc_busy}, 32'd0);
        chk("exc1.addr0", exc_vec_addr, 32'h0);
        check_model("exc1");

        // Exception at PC=0 with reserved code; second request during wait.
        idle_inputs();
        pc_write = 1'b1; pc_next = 32'h0;
        step();
        idle_inputs();
        exc_req = 1'b1; exc_code = 2'b11; exc_vec_data = 32'h0000_0033;
        step();
        chk("exc2.epc", epc_out, 32'hFFFF_FFFC);
        chk("exc2.addr", exc_vec_addr, 32'd253);
        exc_code = 2'b10;
        step();
        chk("exc2.wait_addr", exc_vec_addr, 32'd253);
        step();
        chk("exc2.epc_hold", epc_out, 32'hFFFF_FFFC);
        chk("exc2.addr_hold", exc_vec_addr, 32'd253);
        exc_req = 1'b0;
        step();
        chk("exc2.pc", pc_out, 32'h33);
        chk("exc2.busy", {31'd0, exc_busy}, 32'd0);
        check_model("exc2");

        // Reset asserted while waiting on the vector read.
        exc_req = 1'b1; exc_code = 2'b10;
        step();
        exc_req = 1'b0;
        step();
        chk("rstmid.rd_pre", {31'd0, exc_mem_read}, 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rstmid.pc", pc_out, 32'h0);
        chk("rstmid.epc", epc_out, 32'h0);
        chk("rstmid.busy", {31'd0, exc_busy}, 32'd0);
        chk("rstmid.rd", {31'd0, exc_mem_read}, 32'd0);
        chk("rstmid.addr", exc_vec_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check_model("rstmid");

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            pc_next       = $urandom;
            pc_write      = ($urandom_range(0, 3) == 0);
            pc_write_cond = $urandom_range(0, 1) == 1;
            branch_op     = 2'($urandom_range(0, 3));
            alu_zero      = $urandom_range(0, 1) == 1;
            alu_gt        = $urandom_range(0, 1) == 1;
            exc_req       = ($urandom_range(0, 7) == 0);
            exc_code      = 2'($urandom_range(0, 3));
            exc_vec_data  = $urandom;
            step();
            check_model($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
